// File: rtl/rsp_merge_arbiter.sv
// N-source response merger: per-source DEPTH-entry buffers drained one per cycle into one rsp FIFO port.
// Optional RSP_MERGE_FIXED_PRIO_EN selects fixed priority (source 0 highest) instead of round-robin.
module rsp_merge_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int RSP_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2,
  parameter int SEL_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_SRC-1:0]           i_src_write_en,
  input  logic [NUM_SRC*RSP_WIDTH-1:0] i_src_data,
  input  logic                         i_rsp_fifo_almost_full,
  input  logic                         i_overflow_clr,
  output logic                         o_rsp_write_en,
  output logic [RSP_WIDTH-1:0]         o_rsp_data,
  output logic [SEL_WIDTH-1:0]         o_rsp_src,
  output logic [NUM_SRC-1:0]           o_src_overflow,
  output logic                         o_buf_empty_all
);

  localparam logic [PTR_WIDTH:0] LP_FULL = (PTR_WIDTH+1)'(DEPTH);

  logic [RSP_WIDTH-1:0] r_mem [NUM_SRC][DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr [NUM_SRC];
  logic [PTR_WIDTH-1:0] r_rd_ptr [NUM_SRC];
  logic [PTR_WIDTH:0]   r_cnt [NUM_SRC];
  logic [PTR_WIDTH:0]   w_cnt_nxt [NUM_SRC];
`ifndef RSP_MERGE_FIXED_PRIO_EN
  logic [SEL_WIDTH-1:0] r_rr_ptr;
`endif

  logic                 w_gnt_vld;
  logic [SEL_WIDTH-1:0] w_gnt_idx;
  logic [RSP_WIDTH-1:0] w_head;
  logic [NUM_SRC-1:0]   w_gnt;
  logic [NUM_SRC-1:0]   w_wr_acc;
  logic [NUM_SRC-1:0]   w_drop;
  logic                 w_all_empty_nxt;
  int                   w_start;
  int                   w_idx;

  // Grant looks only at pre-edge counts, so a same-edge write is never bypassed
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_head    = '0;
    w_idx     = 0;
`ifdef RSP_MERGE_FIXED_PRIO_EN
    w_start   = 0;
`else
    w_start   = int'(r_rr_ptr);
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = w_start + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (!w_gnt_vld && !i_rsp_fifo_almost_full && (r_cnt[w_idx] != '0)) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = SEL_WIDTH'(w_idx);
        w_head    = r_mem[w_idx][r_rd_ptr[w_idx]];
      end
    end
  end

  always_comb begin
    w_all_empty_nxt = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_gnt[i]    = w_gnt_vld && (int'(w_gnt_idx) == i);
      w_wr_acc[i] = i_src_write_en[i] && ((r_cnt[i] != LP_FULL) || w_gnt[i]);
      w_drop[i]   = i_src_write_en[i] && !w_wr_acc[i];
      case ({w_wr_acc[i], w_gnt[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - 1'b1;
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
      if (w_cnt_nxt[i] != '0) w_all_empty_nxt = 1'b0;
    end
  end

  // Buffer storage carries no reset; the pointers and counts define validity
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_wr_acc[i]) r_mem[i][r_wr_ptr[i]] <= i_src_data[i*RSP_WIDTH +: RSP_WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
`ifndef RSP_MERGE_FIXED_PRIO_EN
      r_rr_ptr        <= '0;
`endif
      o_rsp_write_en  <= 1'b0;
      o_rsp_data      <= '0;
      o_rsp_src       <= '0;
      o_src_overflow  <= '0;
      o_buf_empty_all <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_wr_acc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_gnt[i])    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        r_cnt[i] <= w_cnt_nxt[i];
      end
`ifndef RSP_MERGE_FIXED_PRIO_EN
      if (w_gnt_vld) r_rr_ptr <= (int'(w_gnt_idx) == NUM_SRC-1) ? '0 : w_gnt_idx + 1'b1;
`endif
      o_rsp_write_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        o_rsp_data <= w_head;
        o_rsp_src  <= w_gnt_idx;
      end
      // A new drop in the same cycle as a clear keeps its bit set
      o_src_overflow  <= w_drop | (o_src_overflow & {NUM_SRC{~i_overflow_clr}});
      o_buf_empty_all <= w_all_empty_nxt && !w_gnt_vld;
    end
  end

endmodule
